// File: rtl/ldm_stm_sequencer_if.sv
// Bus between the decode-stage controller and the LDM/STM/PUSH/POP sequencer.
// The master drives the decoded instruction and the memory handshake. The
// slave (the sequencer) drives the per-transfer strobes and the stall/done signals.
interface ldm_stm_sequencer_if #(
  parameter int ADDR_WIDTH   = 4,
  parameter int LIST_WIDTH   = 8,
  parameter int OFFSET_WIDTH = 8
);
  logic                    start_i;
  logic                    is_load_i;
  logic                    descending_i;
  logic                    writeback_i;
  logic                    extra_reg_i;
  logic [ADDR_WIDTH-1:0]   base_reg_i;
  logic [LIST_WIDTH-1:0]   reg_list_i;
  logic                    mem_ready_i;
  logic                    xfer_valid_o;
  logic [ADDR_WIDTH-1:0]   reg_addr_o;
  logic [OFFSET_WIDTH-1:0] offset_o;
  logic                    mem_write_en_o;
  logic                    reg_write_en_o;
  logic                    wb_en_o;
  logic [OFFSET_WIDTH-1:0] wb_offset_o;
  logic                    stall_o;
  logic                    done_o;

  modport master (
    output start_i, is_load_i, descending_i, writeback_i, extra_reg_i,
           base_reg_i, reg_list_i, mem_ready_i,
    input  xfer_valid_o, reg_addr_o, offset_o, mem_write_en_o, reg_write_en_o,
           wb_en_o, wb_offset_o, stall_o, done_o
  );

  modport slave (
    input  start_i, is_load_i, descending_i, writeback_i, extra_reg_i,
           base_reg_i, reg_list_i, mem_ready_i,
    output xfer_valid_o, reg_addr_o, offset_o, mem_write_en_o, reg_write_en_o,
           wb_en_o, wb_offset_o, stall_o, done_o
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// Multi-cycle register-list sequencer for Thumb LDM/STM/PUSH/POP.
// The sequencer walks the set bits of the latched list, lowest register first.
// The extra LR/PC transfer is kept as the top bit of the mask, so it is always
// the last and highest-addressed transfer. All strobes are combinational from
// the state and the latched registers, and they are forced low while reset is held.
module ldm_stm_sequencer #(
  parameter int ADDR_WIDTH   = 4,
  parameter int LIST_WIDTH   = 8,
  parameter int OFFSET_WIDTH = 8
) (
  input logic                clk_i,
  input logic                reset_i,
  ldm_stm_sequencer_if.slave bus
);
  localparam int CNT_W  = $clog2(LIST_WIDTH + 2);
  localparam int MASK_W = LIST_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [MASK_W-1:0]       r_mask;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        r_total;
  logic                    r_is_load;
  logic                    r_desc;
  logic                    r_wb;

  logic [CNT_W-1:0]        w_start_n;
  logic [LIST_WIDTH-1:0]   w_base_hit_vec;
  logic                    w_start_wb;
  logic [MASK_W-1:0]       w_mask_rest;
  logic                    w_last;
  logic [ADDR_WIDTH-1:0]   w_low_addr;
  logic [OFFSET_WIDTH-1:0] w_k4;
  logic [OFFSET_WIDTH-1:0] w_n4;

  // Number of transfers in the incoming instruction: the list popcount plus the optional LR/PC.
  always_comb begin
    w_start_n = CNT_W'(bus.extra_reg_i);
    for (int i = 0; i < LIST_WIDTH; i++) begin
      w_start_n = w_start_n + CNT_W'(bus.reg_list_i[i]);
    end
  end

  // Base register present in the low list. The explicit compare per bit avoids an out-of-range index.
  for (genvar gi = 0; gi < LIST_WIDTH; gi++) begin : g_base_hit
    assign w_base_hit_vec[gi] = bus.reg_list_i[gi] && (bus.base_reg_i == ADDR_WIDTH'(gi));
  end

  // A load that overwrites its own base keeps the loaded value, so writeback is dropped.
  assign w_start_wb = bus.writeback_i && !(bus.is_load_i && (|w_base_hit_vec));

  // The remaining mask after clearing the lowest set bit. Only one bit left means this is the final transfer.
  assign w_mask_rest = r_mask & (r_mask - MASK_W'(1));
  assign w_last      = (w_mask_rest == '0);

  // Byte offsets 4k and 4N. Two's-complement wraparound gives the descending form 4k-4N.
  assign w_k4 = OFFSET_WIDTH'({r_count, 2'b00});
  assign w_n4 = OFFSET_WIDTH'({r_total, 2'b00});

  // Lowest set register of the remaining mask. If only the extra bit is left, use LR for a store or PC for a load.
  always_comb begin
    w_low_addr = r_is_load ? ADDR_WIDTH'(15) : ADDR_WIDTH'(14);
    for (int i = LIST_WIDTH - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_low_addr = ADDR_WIDTH'(i);
      end
    end
  end

  // State register plus the latched instruction and its progress counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_count   <= '0;
      r_total   <= '0;
      r_is_load <= 1'b0;
      r_desc    <= 1'b0;
      r_wb      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_mask    <= {bus.extra_reg_i, bus.reg_list_i};
            r_count   <= '0;
            r_total   <= w_start_n;
            r_is_load <= bus.is_load_i;
            r_desc    <= bus.descending_i;
            r_wb      <= w_start_wb;
          end
        end
        S_XFER: begin
          if (bus.mem_ready_i) begin
            r_mask  <= w_mask_rest;
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode. Every output defaults to 0 and is forced to 0 during reset.
  always_comb begin
    w_state_next       = r_state;
    bus.xfer_valid_o   = 1'b0;
    bus.reg_addr_o     = '0;
    bus.offset_o       = '0;
    bus.mem_write_en_o = 1'b0;
    bus.reg_write_en_o = 1'b0;
    bus.wb_en_o        = 1'b0;
    bus.wb_offset_o    = '0;
    bus.stall_o        = 1'b0;
    bus.done_o         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          if (w_start_n != '0) begin
            w_state_next = S_XFER;
            bus.stall_o  = 1'b1;
          end else if (bus.writeback_i) begin
            w_state_next = S_WB;
            bus.stall_o  = 1'b1;
          end else begin
            bus.done_o = 1'b1;
          end
        end
      end
      S_XFER: begin
        bus.xfer_valid_o   = 1'b1;
        bus.reg_addr_o     = w_low_addr;
        bus.offset_o       = r_desc ? (w_k4 - w_n4) : w_k4;
        bus.mem_write_en_o = !r_is_load;
        bus.reg_write_en_o = r_is_load && bus.mem_ready_i;
        bus.stall_o        = 1'b1;
        if (bus.mem_ready_i && w_last) begin
          if (r_wb) begin
            w_state_next = S_WB;
          end else begin
            w_state_next = S_IDLE;
            bus.stall_o  = 1'b0;
            bus.done_o   = 1'b1;
          end
        end
      end
      S_WB: begin
        bus.wb_en_o     = 1'b1;
        bus.wb_offset_o = r_desc ? ('0 - w_n4) : w_n4;
        bus.done_o      = 1'b1;
        w_state_next    = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    if (reset_i) begin
      w_state_next       = S_IDLE;
      bus.xfer_valid_o   = 1'b0;
      bus.reg_addr_o     = '0;
      bus.offset_o       = '0;
      bus.mem_write_en_o = 1'b0;
      bus.reg_write_en_o = 1'b0;
      bus.wb_en_o        = 1'b0;
      bus.wb_offset_o    = '0;
      bus.stall_o        = 1'b0;
      bus.done_o         = 1'b0;
    end
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer. The stimulus pushes hand-computed
// per-cycle records. The monitor pops a record whenever the DUT shows any activity.
module tb_ldm_stm_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ldm_stm_sequencer_if #(.ADDR_WIDTH(4), .LIST_WIDTH(8), .OFFSET_WIDTH(8)) bus();

  ldm_stm_sequencer #(.ADDR_WIDTH(4), .LIST_WIDTH(8), .OFFSET_WIDTH(8)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  typedef struct packed {
    logic       xv;
    logic [3:0] addr;
    logic [7:0] off;
    logic       mwe;
    logic       rwe;
    logic       wbe;
    logic [7:0] wbo;
    logic       stall;
    logic       done;
  } rec_t;

  rec_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string cur_test = "reset";

  function automatic rec_t mk(logic xv, logic [3:0] a, logic [7:0] o, logic mwe, logic rwe,
                              logic wbe, logic [7:0] wbo, logic st, logic dn);
    rec_t r;
    r.xv = xv; r.addr = a; r.off = o; r.mwe = mwe; r.rwe = rwe;
    r.wbe = wbe; r.wbo = wbo; r.stall = st; r.done = dn;
    return r;
  endfunction

  function automatic rec_t sample();
    return mk(bus.xfer_valid_o, bus.reg_addr_o, bus.offset_o, bus.mem_write_en_o,
              bus.reg_write_en_o, bus.wb_en_o, bus.wb_offset_o, bus.stall_o, bus.done_o);
  endfunction

  function automatic string fmt(rec_t r);
    return $sformatf("xv=%b reg=%0d off=%h mwe=%b rwe=%b wb=%b wboff=%h stall=%b done=%b",
                     r.xv, r.addr, r.off, r.mwe, r.rwe, r.wbe, r.wbo, r.stall, r.done);
  endfunction

  // Monitor: any active DUT cycle consumes one expected record.
  always @(negedge clk) begin
    rec_t got;
    rec_t e;
    got = sample();
    if (got.xv || got.wbe || got.done || got.stall || got.mwe || got.rwe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected: actual %s, required no activity", cur_test, fmt(got));
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL %s cycle: actual %s, required %s", cur_test, fmt(got), fmt(e));
        end else begin
          $display("ok   %s: %s", cur_test, fmt(got));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic st, logic ld, logic ds, logic wb, logic ex,
                       logic [3:0] base, logic [7:0] list, logic rdy);
    bus.start_i      = st;
    bus.is_load_i    = ld;
    bus.descending_i = ds;
    bus.writeback_i  = wb;
    bus.extra_reg_i  = ex;
    bus.base_reg_i   = base;
    bus.reg_list_i   = list;
    bus.mem_ready_i  = rdy;
  endtask

  task automatic check_quiet(string name);
    rec_t got;
    @(negedge clk);
    got = sample();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s quiet: actual %s, required all zero", name, fmt(got));
    end else begin
      $display("ok   %s: outputs all zero", name);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: actual %0d records left, required 0", cur_test, exp_q.size());
      exp_q.delete();
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual time exceeded, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd0, 8'h00, 1'b0);
    repeat (3) cyc();
    check_quiet("reset");
    cyc();
    reset = 1'b0;
    cyc();

    // STM {r0,r2,r7}, ascending
    cur_test = "stm3";
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 2, 8'h04, 1, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 7, 8'h08, 1, 0, 0, 8'h00, 0, 1));
    drive(1, 0, 0, 0, 0, 4'd13, 8'b1000_0101, 1'b1);
    cyc();
    bus.start_i = 1'b0;
    drain();

    // PUSH {r4, LR} with SP writeback
    cur_test = "push";
    exp_q.push_back(mk(0, 0,  8'h00, 0, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 4,  8'hF8, 1, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 14, 8'hFC, 1, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(0, 0,  8'h00, 0, 0, 1, 8'hF8, 0, 1));
    drive(1, 0, 1, 1, 1, 4'd13, 8'b0001_0000, 1'b1);
    cyc();
    bus.start_i = 1'b0;
    drain();

    // POP {r1, PC}: two wait cycles on the first transfer; start and list toggled mid-op must be ignored
    cur_test = "pop";
    exp_q.push_back(mk(0, 0,  8'h00, 0, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 1,  8'h00, 0, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 1,  8'h00, 0, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 1,  8'h00, 0, 1, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 15, 8'h04, 0, 1, 0, 8'h00, 0, 1));
    drive(1, 1, 0, 0, 1, 4'd13, 8'b0000_0010, 1'b0);
    cyc();
    bus.reg_list_i = 8'hFF;
    bus.is_load_i  = 1'b0;
    bus.mem_ready_i = 1'b0;
    cyc();
    bus.mem_ready_i = 1'b0;
    cyc();
    bus.mem_ready_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
    drain();

    // LDM r2!, {r1,r2,r3}: base is in the list, so writeback is suppressed
    cur_test = "ldm_base";
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 1, 8'h00, 0, 1, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 2, 8'h04, 0, 1, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 3, 8'h08, 0, 1, 0, 8'h00, 0, 1));
    drive(1, 1, 0, 1, 0, 4'd2, 8'b0000_1110, 1'b1);
    cyc();
    bus.start_i = 1'b0;
    drain();

    // Empty list, no writeback: done in the start cycle, no stall
    cur_test = "empty";
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1));
    drive(1, 0, 0, 0, 0, 4'd13, 8'h00, 1'b1);
    cyc();
    bus.start_i = 1'b0;
    check_quiet("empty_idle");
    drain();

    // Empty list with writeback: a single WB cycle with offset 0
    cur_test = "empty_wb";
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 1));
    drive(1, 0, 1, 1, 0, 4'd13, 8'h00, 1'b1);
    cyc();
    bus.start_i = 1'b0;
    drain();

    // Reset during the second transfer of an 8-register STM
    cur_test = "reset_mid";
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0));
    drive(1, 0, 0, 0, 0, 4'd13, 8'hFF, 1'b1);
    cyc();
    bus.start_i = 1'b0;
    cyc();
    reset = 1'b1;
    check_quiet("reset_during_xfer");
    cyc();
    reset = 1'b0;
    check_quiet("after_reset");
    cyc();
    cur_test = "restart";
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0));
    exp_q.push_back(mk(1, 1, 8'h04, 1, 0, 0, 8'h00, 0, 1));
    drive(1, 0, 0, 0, 0, 4'd13, 8'b0000_0011, 1'b1);
    cyc();
    bus.start_i = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
